multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have ports: clk_i in 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst_i in 1, synchronous active-high reset.
REQ-003 SHALL have ports: op_i in 6, instr[31:26]; funct_i in 6, instr[5:0]; zero_i in 1, ALU zero flag.
REQ-004 SHALL have outputs, 1 bit each: pc_write_o, iord_o, mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o.
REQ-005 SHALL have 2-bit outputs alu_src_b_o (00 regB, 01 const 4, 10 sign_imm, 11 sign_imm<<2) and pc_src_o (00 ALU result, 01 ALUOut reg, 10 jump target).
REQ-006 SHALL have outputs alu_control_o 4 bits, state_o 4 bits (current state), illegal_o 1 bit, retired_o 32 bits (retired-instruction count).

Function
REQ-007 SHALL be a Moore FSM with states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH next cycle with no writes.
REQ-008 SHALL transition FETCH->DECODE unconditionally.
REQ-009 SHALL transition DECODE by op_i: 100011/101011->MEMADR; 000000->EXEC; 000100->BRANCH; 001000->ADDIEX; 000010->JUMP; any other->FETCH.
REQ-010 SHALL transition MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB; and MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-011 SHALL drive, in FETCH: iord 0, ir_write 1, alu_src_a 0, alu_src_b 01, ADD, pc_src 00, pc_write 1.
REQ-012 SHALL drive, in DECODE: alu_src_a 0, alu_src_b 11, ADD, to precompute the branch target.
REQ-013 SHALL drive, in MEMADR and ADDIEX: alu_src_a 1, alu_src_b 10, ADD; in MEMRD: iord 1.
REQ-014 SHALL drive, in MEMWB: reg_dst 0, mem_to_reg 1, reg_write 1; in MEMWR: iord 1, mem_write 1.
REQ-015 SHALL drive, in ALUWB: reg_dst 1, mem_to_reg 0, reg_write 1; in ADDIWB: reg_dst 0, mem_to_reg 0, reg_write 1.
REQ-016 SHALL drive, in EXEC: alu_src_a 1, alu_src_b 00, alu_control from funct_i: 100000 ADD=0010, 100010 SUB=0110, 100100 AND=0000, 100101 OR=0001, 101010 SLT=0111; other funct gives ADD and illegal_o.
REQ-017 SHALL drive, in BRANCH: alu_src_a 1, alu_src_b 00, SUB, pc_src 01, pc_write = zero_i (combinational).
REQ-018 SHALL drive, in JUMP: pc_src 10, pc_write 1.
REQ-019 SHALL hold every output not listed for a state at 0, with alu_control ADD=0010.
REQ-020 SHALL assert illegal_o for exactly one cycle in DECODE on an unsupported opcode, and throughout EXEC on an unsupported funct.
REQ-021 SHALL increment retired_o by 1, wrapping 0xFFFFFFFF->0, on each cycle whose next state is FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP; illegal opcodes and codes 12-15 do not retire.
REQ-022 SHALL take cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.

Reset
REQ-023 SHALL, while rst_i is high at a clock edge, load state FETCH and clear retired_o to 0, aborting any in-flight instruction with no further writes.
REQ-024 SHALL force pc_write_o, ir_write_o, mem_write_o and reg_write_o to 0 while rst_i is high; other outputs take FETCH values.

Configuration
REQ-025 SHALL, with CTRL_MEM_READY_EN defined, add input mem_ready_i 1 bit, hold FETCH, MEMRD and MEMWR until mem_ready_i is 1 with outputs stable, and gate ir_write and pc_write in FETCH with mem_ready_i.
REQ-026 SHALL, without CTRL_MEM_READY_EN, omit mem_ready_i and treat memory as always ready, as in REQ-022.

Verification
REQ-027 SHALL verify reset: rst_i 1 for 2 cycles -> state_o 0, retired_o 0, all write enables 0; first cycle after release -> pc_write 1, ir_write 1.
REQ-028 SHALL verify lw: op 100011 -> states 0,1,2,3,4,0; reg_write 1 and mem_to_reg 1 only in state 4; retired_o +1.
REQ-029 SHALL verify beq: op 000100 with zero_i 1 -> pc_write 1, pc_src 01 in state 8; with zero_i 0 -> pc_write 0; both retire after 3 cycles.
REQ-030 SHALL verify R-type: op 0, funct 101010 -> alu_control 0111 in EXEC; funct 111111 -> illegal_o 1 in EXEC.
REQ-031 SHALL verify illegal opcode and mid-instruction reset: op 111111 -> illegal_o pulse, back to FETCH, retired_o unchanged; rst_i in MEMRD -> next state FETCH, no reg_write.
REQ-032 SHALL verify, with CTRL_MEM_READY_EN, that mem_ready_i 0 for 3 cycles in MEMRD -> state held at 3, exits one cycle after mem_ready_i rises.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// Moore FSM controller for a multi-cycle MIPS-style datapath, with a retired-instruction counter.
// Optional macro CTRL_MEM_READY_EN adds mem_ready_i and stalls FETCH/MEMRD/MEMWR on it.
module multi_cycle_controller (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef CTRL_MEM_READY_EN
  input  logic        mem_ready_i,
`endif
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  output logic        pc_write_o,
  output logic        iord_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        mem_to_reg_o,
  output logic        reg_dst_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  pc_src_o,
  output logic [3:0]  alu_control_o,
  output logic [3:0]  state_o,
  output logic        illegal_o,
  output logic [31:0] retired_o
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7,
    BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110;

  state_t state, next, dec;
  logic   mem_rdy, retire;

`ifdef CTRL_MEM_READY_EN
  assign mem_rdy = mem_ready_i;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= FETCH;
      retired_o <= '0;
    end else begin
      state <= next;
      if (retire) retired_o <= retired_o + 32'd1;
    end
  end

  always_comb begin
    next   = FETCH;
    retire = 1'b0;
    case (state)
      FETCH:  next = mem_rdy ? DECODE : FETCH;
      DECODE: begin
        case (op_i)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXEC;
          OP_BEQ:       next = BRANCH;
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          default:      next = FETCH;
        endcase
      end
      MEMADR: next = (op_i == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  next = mem_rdy ? MEMWB : MEMRD;
      MEMWR:  begin
        next   = mem_rdy ? FETCH : MEMWR;
        retire = mem_rdy;
      end
      EXEC:   next = ALUWB;
      ADDIEX: next = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
        next   = FETCH;
        retire = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

  // While in reset the output decode behaves as FETCH, with all write strobes suppressed.
  assign dec     = rst_i ? FETCH : state;
  assign state_o = state;

  always_comb begin
    pc_write_o    = 1'b0;
    iord_o        = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_dst_o     = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    pc_src_o      = 2'b00;
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (dec)
      FETCH: begin
        ir_write_o  = mem_rdy;
        pc_write_o  = mem_rdy;
        alu_src_b_o = 2'b01;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        illegal_o   = !(op_i inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J});
      end
      MEMADR, ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      MEMRD: iord_o = 1'b1;
      MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      MEMWR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      EXEC: begin
        alu_src_a_o = 1'b1;
        case (funct_i)
          6'b100000: alu_control_o = ALU_ADD;
          6'b100010: alu_control_o = ALU_SUB;
          6'b100100: alu_control_o = 4'b0000;
          6'b100101: alu_control_o = 4'b0001;
          6'b101010: alu_control_o = 4'b0111;
          default:   illegal_o     = 1'b1;
        endcase
      end
      ALUWB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      ADDIWB: reg_write_o = 1'b1;
      BRANCH: begin
        alu_src_a_o   = 1'b1;
        alu_control_o = ALU_SUB;
        pc_src_o      = 2'b01;
        pc_write_o    = zero_i;
      end
      JUMP: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
      end
      default: ;
    endcase
    if (rst_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
    end
  end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller; covers CTRL_MEM_READY_EN stalls when that macro is defined.
module tb_multi_cycle_controller;
  logic        clk_i = 1'b0, rst_i, zero_i;
  logic [5:0]  op_i, funct_i;
  logic        pc_write_o, iord_o, mem_write_o, ir_write_o, mem_to_reg_o;
  logic        reg_dst_o, reg_write_o, alu_src_a_o, illegal_o;
  logic [1:0]  alu_src_b_o, pc_src_o;
  logic [3:0]  alu_control_o, state_o;
  logic [31:0] retired_o;
  int          vectors = 0, fails = 0;
`ifdef CTRL_MEM_READY_EN
  logic        mem_ready_i = 1'b1;
`endif

  multi_cycle_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
`ifdef CTRL_MEM_READY_EN
    .mem_ready_i(mem_ready_i),
`endif
    .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
    .pc_write_o(pc_write_o), .iord_o(iord_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .pc_src_o(pc_src_o), .alu_control_o(alu_control_o), .state_o(state_o),
    .illegal_o(illegal_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; op_i = 6'b0; funct_i = 6'b0; zero_i = 1'b0;
    step(); step();
    chk("rst_state", {28'b0, state_o}, 0);
    chk("rst_retired", retired_o, 0);
    chk("rst_writes", {28'b0, pc_write_o, ir_write_o, mem_write_o, reg_write_o}, 0);
    chk("rst_alu", {28'b0, alu_control_o}, 4'b0010);
    rst_i = 1'b0; #1;
    chk("rel_pc_ir_write", {30'b0, pc_write_o, ir_write_o}, 2'b11);
    chk("rel_alu_src_b", {30'b0, alu_src_b_o}, 2'b01);

    // lw: 0,1,2,3,4,0
    op_i = 6'b100011;
    step(); chk("lw_s1", {28'b0, state_o}, 1);
    chk("dec_alu_src_b", {30'b0, alu_src_b_o}, 2'b11);
    chk("dec_writes", {28'b0, pc_write_o, ir_write_o, reg_write_o, illegal_o}, 0);
    step(); chk("lw_s2", {28'b0, state_o}, 2);
    chk("lw_adr", {29'b0, alu_src_a_o, alu_src_b_o}, 3'b110);
    step(); chk("lw_s3", {28'b0, state_o}, 3);
    chk("lw_rd", {29'b0, iord_o, reg_write_o, mem_to_reg_o}, 3'b100);
    step(); chk("lw_s4", {28'b0, state_o}, 4);
    chk("lw_wb", {29'b0, reg_write_o, mem_to_reg_o, reg_dst_o}, 3'b110);
    step(); chk("lw_s0", {28'b0, state_o}, 0);
    chk("lw_ret", retired_o, 1);

    // beq taken / not taken
    op_i = 6'b000100; zero_i = 1'b1;
    step(); step(); chk("beq1_s8", {28'b0, state_o}, 8);
    chk("beq1_ctl", {25'b0, pc_write_o, pc_src_o, alu_control_o}, {1'b1, 2'b01, 4'b0110});
    step(); chk("beq1_ret", retired_o, 2);
    zero_i = 1'b0;
    step(); step(); chk("beq0_pcw", {31'b0, pc_write_o}, 0);
    step(); chk("beq0_ret", {retired_o[27:0], state_o}, {28'd3, 4'd0});

    // R-type SLT, then bad funct
    op_i = 6'b000000; funct_i = 6'b101010;
    step(); step(); chk("slt_exec", {23'b0, state_o, illegal_o, alu_control_o}, {4'd6, 1'b0, 4'b0111});
    step(); chk("slt_wb", {29'b0, reg_write_o, reg_dst_o, mem_to_reg_o}, 3'b110);
    step(); chk("slt_ret", retired_o, 4);
    funct_i = 6'b111111;
    step(); step(); chk("badf_exec", {27'b0, illegal_o, alu_control_o}, {1'b1, 4'b0010});
    step(); step(); chk("badf_ret", retired_o, 5);

    // illegal opcode: one-cycle pulse, no retire
    op_i = 6'b111111;
    step(); chk("ill_dec", {27'b0, state_o, illegal_o}, {4'd1, 1'b1});
    step(); chk("ill_back", {27'b0, state_o, illegal_o}, {4'd0, 1'b0});
    chk("ill_ret", retired_o, 5);

    // jump
    op_i = 6'b000010;
    step(); step(); chk("j_ctl", {25'b0, state_o, pc_src_o, pc_write_o}, {4'd11, 2'b10, 1'b1});
    step(); chk("j_ret", retired_o, 6);

    // sw
    op_i = 6'b101011;
    step(); step(); step();
    chk("sw_wr", {25'b0, state_o, iord_o, mem_write_o, reg_write_o}, {4'd5, 3'b110});
    step(); chk("sw_ret", {retired_o[27:0], state_o}, {28'd7, 4'd0});

    // addi
    op_i = 6'b001000;
    step(); step(); chk("addi_ex", {26'b0, state_o, alu_src_b_o}, {4'd9, 2'b10});
    step(); chk("addi_wb", {25'b0, state_o, reg_write_o, reg_dst_o, mem_to_reg_o}, {4'd10, 3'b100});
    step(); chk("addi_ret", retired_o, 8);

`ifdef CTRL_MEM_READY_EN
    op_i = 6'b100011;
    step(); step(); step(); mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_hold", {28'b0, state_o}, 3);
    end
    mem_ready_i = 1'b1;
    step(); chk("stall_exit", {28'b0, state_o}, 4);
    step(); chk("stall_ret", retired_o, 9);
`endif

    // reset in MEMRD aborts the load
    op_i = 6'b100011;
    step(); step(); step(); chk("mr_s3", {28'b0, state_o}, 3);
    rst_i = 1'b1; #1;
    chk("mr_rw_in_rst", {31'b0, reg_write_o}, 0);
    step(); chk("mr_state", {28'b0, state_o}, 0);
    chk("mr_regw", {31'b0, reg_write_o}, 0);
    chk("mr_ret", retired_o, 0);
    rst_i = 1'b0;
    step(); chk("mr_resume", {28'b0, state_o}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
